cond_branch_unit: RTL and testbench
===================================

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 SHALL provide parameter CNT_WIDTH, default 8, width of the taken-branch counter.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port flag_wr_en  input  1  load flags_in into the flag store this cycle.
REQ-005 SHALL provide port flags_in  input  4  new flags {N,Z,C,V} from the ALU.
REQ-006 SHALL provide port eval_valid  input  1  branch-evaluation request present.
REQ-007 SHALL provide port cond  input  4  condition code of the request.
REQ-008 SHALL provide port eval_ready  output  1  unit can accept a request this cycle.
REQ-009 SHALL provide port result_valid  output  1  registered result available.
REQ-010 SHALL provide port taken  output  1  branch-taken result; meaningful only while result_valid=1.
REQ-011 SHALL provide port result_ack  input  1  consumer takes the result this cycle.
REQ-012 SHALL provide port flags_q  output  4  current stored flags {N,Z,C,V}.
REQ-013 SHALL provide port count_clr  input  1  synchronous clear of taken_count.
REQ-014 SHALL provide port taken_count  output  CNT_WIDTH  saturating count of accepted requests that evaluated taken.

Function
REQ-015 SHALL update flags_q to flags_in at the clock edge when flag_wr_en=1; otherwise flags_q SHALL hold.
REQ-016 SHALL evaluate accepted requests against the effective flags: flags_in when flag_wr_en=1 in the same cycle (bypass), else flags_q.
REQ-017 SHALL decode cond as: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 always taken.
REQ-018 SHALL implement a two-state FSM: EMPTY (result_valid=0) and FULL (result_valid=1).
REQ-019 SHALL drive eval_ready = 1 in EMPTY, and = result_ack in FULL (combinational; back-to-back acceptance allowed).
REQ-020 SHALL accept a request on a cycle with eval_valid=1 and eval_ready=1; latency to result_valid SHALL be exactly 1 cycle.
REQ-021 EMPTY -> FULL on acceptance; FULL -> EMPTY on result_ack without acceptance; FULL stays FULL, loading the new taken, on result_ack with acceptance; FULL holds taken unchanged while result_ack=0.
REQ-022 SHALL ignore result_ack in EMPTY.
REQ-023 SHALL increment taken_count by 1 on each acceptance whose evaluation is taken, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-024 SHALL zero taken_count on count_clr=1; count_clr SHALL take priority over a simultaneous increment.
REQ-025 SHALL keep flag updates independent of the handshake: flags update even while eval_ready=0, and a stalled request (eval_ready=0) is not evaluated until accepted.

Reset
REQ-026 SHALL, while reset=1, force flags_q=0000, result_valid=0, taken=0, taken_count=0, FSM=EMPTY, independent of clk.
REQ-027 SHALL discard any pending result and any request presented in the cycle reset is asserted; the first acceptance SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-028 Reset mid-operation: FULL with taken=1, count=5, assert reset between edges -> immediately result_valid=0, taken=0, flags_q=0000, taken_count=0.
REQ-029 Bypass: flags_q=0000, same cycle flag_wr_en=1 flags_in=0100, eval cond=0000 -> next cycle result_valid=1, taken=1, flags_q=0100.
REQ-030 Condition sweep: for flags {N,Z,C,V} = 1001, 0010, 1100, all 16 cond codes -> taken matches REQ-017 (e.g. flags 1001 GE=1, GT=1, LT=0; flags 0010 HI=1, LS=0).
REQ-031 Backpressure: FULL, result_ack=0 for 3 cycles with eval_valid=1 -> eval_ready=0, taken stable, count unchanged; ack with eval_valid=1 -> new result next cycle, no bubble.
REQ-032 Counter: CNT_WIDTH=4, 17 back-to-back cond=1110 requests -> taken_count saturates at 15; count_clr asserted together with a taken acceptance -> taken_count=0.

Source files
------------

// File: rtl/cond_branch_unit.sv
// rtl/cond_branch_unit.sv - conditional branch evaluator with flag store, one-entry result buffer and taken counter
module cond_branch_unit #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flag_wr_en,
   input  logic [3:0]           flags_in,
   input  logic                 eval_valid,
   input  logic [3:0]           cond,
   output logic                 eval_ready,
   output logic                 result_valid,
   output logic                 taken,
   input  logic                 result_ack,
   output logic [3:0]           flags_q,
   input  logic                 count_clr,
   output logic [CNT_WIDTH-1:0] taken_count
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic                 r_state;
   logic                 r_taken;
   logic [3:0]           r_flags;
   logic [CNT_WIDTH-1:0] r_count;

   logic       w_accept;
   logic [3:0] w_eff_flags;
   logic       w_n;
   logic       w_z;
   logic       w_c;
   logic       w_v;
   logic       w_taken;

   // A full buffer can still accept when the consumer drains it in the same cycle
   assign eval_ready   = (r_state == ST_EMPTY) | result_ack;
   assign w_accept     = eval_valid & eval_ready;
   assign result_valid = (r_state == ST_FULL);
   assign taken        = r_taken;
   assign flags_q      = r_flags;
   assign taken_count  = r_count;

   // Flags written this cycle are visible to the request evaluated this cycle
   assign w_eff_flags = flag_wr_en ? flags_in : r_flags;
   assign w_n = w_eff_flags[3];
   assign w_z = w_eff_flags[2];
   assign w_c = w_eff_flags[1];
   assign w_v = w_eff_flags[0];

   // Condition-code decode against the effective flags
   always_comb begin
      w_taken = 1'b0;
      case (cond)
         4'b0000: w_taken = w_z;
         4'b0001: w_taken = ~w_z;
         4'b0010: w_taken = w_c;
         4'b0011: w_taken = ~w_c;
         4'b0100: w_taken = w_n;
         4'b0101: w_taken = ~w_n;
         4'b0110: w_taken = w_v;
         4'b0111: w_taken = ~w_v;
         4'b1000: w_taken = w_c & ~w_z;
         4'b1001: w_taken = ~w_c | w_z;
         4'b1010: w_taken = (w_n == w_v);
         4'b1011: w_taken = (w_n != w_v);
         4'b1100: w_taken = ~w_z & (w_n == w_v);
         4'b1101: w_taken = w_z | (w_n != w_v);
         default: w_taken = 1'b1;
      endcase
   end

   // Flag store, updated regardless of the evaluation handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_flags <= 4'b0000;
      end else if (flag_wr_en) begin
         r_flags <= flags_in;
      end
   end

   // Result buffer FSM: EMPTY/FULL with registered taken bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
         r_taken <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_state <= ST_FULL;
                  r_taken <= w_taken;
               end
            end
            default: begin
               if (w_accept) begin
                  r_taken <= w_taken;
               end else if (result_ack) begin
                  r_state <= ST_EMPTY;
               end
            end
         endcase
      end
   end

   // Saturating count of taken acceptances; clear wins over increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (count_clr) begin
         r_count <= '0;
      end else if (w_accept && w_taken && (r_count != CNT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb/tb_cond_branch_unit.sv - randomized and directed self-checking bench for cond_branch_unit
module tb_cond_branch_unit;

   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          flag_wr_en;
   logic [3:0]    flags_in;
   logic          eval_valid;
   logic [3:0]    cond;
   logic          eval_ready;
   logic          result_valid;
   logic          taken;
   logic          result_ack;
   logic [3:0]    flags_q;
   logic          count_clr;
   logic [CW-1:0] taken_count;

   int checks = 0;
   int errors = 0;

   bit [3:0] m_flags;
   bit       m_full;
   bit       m_taken;
   int       m_count;

   bit [3:0] n_flags;
   bit       n_full;
   bit       n_taken;
   int       n_count;

   cond_branch_unit #(.CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .flag_wr_en   (flag_wr_en),
      .flags_in     (flags_in),
      .eval_valid   (eval_valid),
      .cond         (cond),
      .eval_ready   (eval_ready),
      .result_valid (result_valid),
      .taken        (taken),
      .result_ack   (result_ack),
      .flags_q      (flags_q),
      .count_clr    (count_clr),
      .taken_count  (taken_count)
   );

   always #5 clk = ~clk;

   // Conditions come in complementary pairs: even code is the base test, odd code its inverse
   function automatic bit ref_taken(input bit [3:0] c, input bit [3:0] f);
      bit n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: return 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flags = 4'b0000;
      m_full  = 1'b0;
      m_taken = 1'b0;
      m_count = 0;
   endtask

   task automatic idle_inputs();
      flag_wr_en = 1'b0;
      flags_in   = 4'b0000;
      eval_valid = 1'b0;
      cond       = 4'b0000;
      result_ack = 1'b0;
      count_clr  = 1'b0;
   endtask

   // One clock: compare at negedge with current inputs, then advance the model across the edge
   task automatic cycle();
      bit ready_exp, acc, t;
      @(negedge clk);
      ready_exp = !m_full || result_ack;
      chk("result_valid", result_valid, m_full);
      chk("eval_ready", eval_ready, ready_exp);
      chk("flags_q", flags_q, m_flags);
      chk("taken_count", taken_count, m_count);
      if (m_full) chk("taken", taken, m_taken);
      acc = eval_valid && ready_exp;
      t = ref_taken(cond, flag_wr_en ? flags_in : m_flags);
      n_flags = flag_wr_en ? flags_in : m_flags;
      n_full = m_full;
      n_taken = m_taken;
      if (acc) begin
         n_full = 1'b1;
         n_taken = t;
      end else if (m_full && result_ack) begin
         n_full = 1'b0;
      end
      n_count = m_count;
      if (count_clr) n_count = 0;
      else if (acc && t && m_count < CMAX) n_count = m_count + 1;
      @(posedge clk);
      #1;
      m_flags = n_flags;
      m_full  = n_full;
      m_taken = n_taken;
      m_count = n_count;
   endtask

   initial begin
      bit [3:0] sweep_flags [3];
      sweep_flags[0] = 4'b1001;
      sweep_flags[1] = 4'b0010;
      sweep_flags[2] = 4'b1100;

      reset = 1'b1;
      idle_inputs();
      eval_valid = 1'b1;
      model_reset();
      #12;
      chk("rst_valid", result_valid, 0);
      chk("rst_taken", taken, 0);
      chk("rst_flags", flags_q, 0);
      chk("rst_count", taken_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();

      // Bypass: flags written and used in the same cycle
      flag_wr_en = 1'b1; flags_in = 4'b0100; eval_valid = 1'b1; cond = 4'b0000;
      cycle();
      chk("byp_valid", result_valid, 1);
      chk("byp_taken", taken, 1);
      chk("byp_flags", flags_q, 4'b0100);
      idle_inputs();
      result_ack = 1'b1;
      cycle();

      // Condition sweep over three flag patterns
      for (int f = 0; f < 3; f++) begin
         idle_inputs();
         flag_wr_en = 1'b1; flags_in = sweep_flags[f];
         cycle();
         for (int c = 0; c < 16; c++) begin
            idle_inputs();
            eval_valid = 1'b1; cond = 4'(c); result_ack = 1'b1;
            cycle();
            if (f == 0 && c == 10) chk("sw_1001_GE", taken, 1);
            if (f == 0 && c == 11) chk("sw_1001_LT", taken, 0);
            if (f == 0 && c == 12) chk("sw_1001_GT", taken, 1);
            if (f == 1 && c == 8)  chk("sw_0010_HI", taken, 1);
            if (f == 1 && c == 9)  chk("sw_0010_LS", taken, 0);
         end
      end

      // Backpressure: hold a taken result while a not-taken request waits
      idle_inputs();
      result_ack = 1'b1;
      flag_wr_en = 1'b1; flags_in = 4'b0000;
      cycle();
      idle_inputs();
      eval_valid = 1'b1; cond = 4'b1110;
      cycle();
      cond = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_ready", eval_ready, 0);
         chk("bp_taken", taken, 1);
      end
      result_ack = 1'b1;
      cycle();
      chk("bp_valid_after", result_valid, 1);
      chk("bp_taken_after", taken, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         flag_wr_en = ($urandom_range(0, 3) == 0);
         flags_in   = 4'($urandom);
         eval_valid = ($urandom_range(0, 3) != 0);
         cond       = 4'($urandom);
         result_ack = ($urandom_range(0, 2) != 0);
         count_clr  = ($urandom_range(0, 40) == 0);
         cycle();
      end

      // Counter saturation and clear priority
      idle_inputs();
      count_clr = 1'b1; result_ack = 1'b1;
      cycle();
      count_clr = 1'b0;
      eval_valid = 1'b1; cond = 4'b1110;
      for (int i = 0; i < 17; i++) cycle();
      chk("cnt_sat", taken_count, 15);
      count_clr = 1'b1;
      cycle();
      chk("cnt_clr_prio", taken_count, 0);

      // Reset mid-operation from FULL, taken=1, count=5
      count_clr = 1'b0;
      flag_wr_en = 1'b1; flags_in = 4'b1111;
      for (int i = 0; i < 5; i++) cycle();
      chk("pre_rst_count", taken_count, 5);
      chk("pre_rst_full", result_valid, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", result_valid, 0);
      chk("mid_rst_taken", taken, 0);
      chk("mid_rst_flags", flags_q, 0);
      chk("mid_rst_count", taken_count, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();
      eval_valid = 1'b1; cond = 4'b1111;
      cycle();
      chk("post_rst_accept", result_valid, 1);
      chk("post_rst_count", taken_count, 1);
      idle_inputs();
      result_ack = 1'b1;
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
